// File: rtl/maple_defs.sv
// Shared definitions for the Maple port mux: switch FSM encoding and pin levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package maple_defs;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_GUARD  = 2'd2
  } state_e;

  // Level of an undriven (pulled-up) Maple line; also the idle bus level.
  localparam logic PIN_RELEASED = 1'b1;

endpackage

// File: rtl/maple_line_filter.sv
// One Maple line across all ports: per-port sync chains plus a glitch filter on the selected port.
// Latency: SYNC_STAGES + FILTER_LEN cycles from pin edge to filt_o.
// Backpressure: none; preset_i overrides the filter for one cycle.
module maple_line_filter
  import maple_defs::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] raw_i,
  input  logic [SEL_W-1:0]     sel_i,
  input  logic                 preset_i,
  input  logic [SEL_W-1:0]     preset_sel_i,
  output logic [NUM_PORTS-1:0] sync_o,
  output logic                 filt_o
);

  // Run counter only has to hold 0..FILTER_LEN-1.
  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [NUM_PORTS-1:0][SYNC_STAGES-1:0] chain_q;
  logic [RUN_W-1:0]                      run_q, run_d;
  logic                                  filt_q, filt_d;
  logic                                  cur;

  // Synchroniser chains for every port; they start at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {(NUM_PORTS*SYNC_STAGES){PIN_RELEASED}};
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        chain_q[p] <= {chain_q[p][SYNC_STAGES-2:0], raw_i[p]};
      end
    end
  end

  // Expose the last stage of each chain (also feeds the idle detectors).
  always_comb begin
    sync_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sync_o[p] = chain_q[p][SYNC_STAGES-1];
    end
  end

  assign cur = sync_o[sel_i];

  // Output follows the synced value only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (preset_i) begin
      filt_d = sync_o[preset_sel_i];
    end else if (cur != filt_q) begin
      if (run_q == RUN_W'(FILTER_LEN - 1)) begin
        filt_d = cur;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= PIN_RELEASED;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ocpin.sv
// Open-collector pin cell: pulls the pad low when enabled with a 0, else releases it.
// Latency: combinational in both directions.
// Backpressure: none.
module ocpin (
  inout  wire  pad,
  input  logic en,
  input  logic drv,
  output logic rd
);

  assign pad = (en && !drv) ? 1'b0 : 1'bz;
  assign rd  = pad;

endmodule

// File: rtl/maple_port_mux.sv
// N-port Maple front end: guarded port switching, synced/filtered receive, per-port idle flags.
// Latency: drive path combinational; receive SYNC_STAGES+FILTER_LEN; switch 2+GUARD_CYCLES cycles.
// Backpressure: sel_ready low while draining/guarding; requests then are dropped, not queued.
module maple_port_mux
  import maple_defs::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int SEL_W        = $clog2(NUM_PORTS),
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 3,
  parameter int GUARD_CYCLES = 16,
  parameter int IDLE_CYCLES  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire  [NUM_PORTS-1:0] pin1,
  inout  wire  [NUM_PORTS-1:0] pin5,
  input  logic [SEL_W-1:0]     sel_req,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  output logic                 sel_err,
  output logic [SEL_W-1:0]     active_sel,
  input  logic                 out_p1,
  input  logic                 out_p5,
  input  logic                 oe,
  output logic                 in_p1,
  output logic                 in_p5,
  output logic [NUM_PORTS-1:0] port_idle
);

  localparam int GCNT_W = $clog2(GUARD_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [SEL_W:0] PORT_LIMIT = (SEL_W+1)'(NUM_PORTS);

  state_e                            state_q, state_d;
  logic [SEL_W-1:0]                  active_q, active_d;
  logic [SEL_W-1:0]                  req_q, req_d;
  logic [GCNT_W-1:0]                 gcnt_q, gcnt_d;
  logic                              err_q, err_d;
  logic                              preset;
  logic [NUM_PORTS-1:0]              pin_en, raw1, raw5, sync1, sync5;
  logic [WARM_W-1:0]                 warm_q;
  logic                              warm_done;
  logic [NUM_PORTS-1:0][IDLE_W-1:0]  idle_q;

  // Switch FSM next state: accept in ACTIVE, wait for the engine to let go, then hold the guard.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    req_d     = req_q;
    gcnt_d    = gcnt_q;
    err_d     = 1'b0;
    preset    = 1'b0;
    sel_ready = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        sel_ready = 1'b1;
        if (sel_valid) begin
          if ({1'b0, sel_req} >= PORT_LIMIT) begin
            err_d = 1'b1;
          end else if (sel_req != active_q) begin
            req_d   = sel_req;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!oe) begin
          state_d = ST_GUARD;
          gcnt_d  = '0;
        end
      end
      ST_GUARD: begin
        if (gcnt_q == GCNT_W'(GUARD_CYCLES - 1)) begin
          state_d  = ST_ACTIVE;
          active_d = req_q;
          preset   = 1'b1;
          gcnt_d   = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  // Switch FSM registers; reset mid-switch simply abandons the pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ACTIVE;
      active_q <= '0;
      req_q    <= '0;
      gcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      req_q    <= req_d;
      gcnt_q   <= gcnt_d;
      err_q    <= err_d;
    end
  end

  assign active_sel = active_q;
  assign sel_err    = err_q;

  // Only the connected port may be driven, and only while settled in ACTIVE.
  always_comb begin
    pin_en = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pin_en[p] = oe && (state_q == ST_ACTIVE) && (active_q == SEL_W'(p));
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pin
    ocpin u_p1 (.pad(pin1[g]), .en(pin_en[g]), .drv(out_p1), .rd(raw1[g]));
    ocpin u_p5 (.pad(pin5[g]), .en(pin_en[g]), .drv(out_p5), .rd(raw5[g]));
  end

  maple_line_filter #(
    .NUM_PORTS(NUM_PORTS), .SEL_W(SEL_W), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)
  ) u_line1 (
    .clk(clk), .rst(rst), .raw_i(raw1), .sel_i(active_q), .preset_i(preset),
    .preset_sel_i(req_q), .sync_o(sync1), .filt_o(in_p1)
  );

  maple_line_filter #(
    .NUM_PORTS(NUM_PORTS), .SEL_W(SEL_W), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)
  ) u_line5 (
    .clk(clk), .rst(rst), .raw_i(raw5), .sel_i(active_q), .preset_i(preset),
    .preset_sel_i(req_q), .sync_o(sync5), .filt_o(in_p5)
  );

  assign warm_done = (warm_q == WARM_W'(SYNC_STAGES));

  // Sync flops wake up at the released level, not the real pin; wait until they are refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q <= '0;
    end else if (!warm_done) begin
      warm_q <= warm_q + 1'b1;
    end
  end

  // Per-port saturating high-time counters for idle / presence detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!warm_done || !(sync1[p] && sync5[p])) begin
          idle_q[p] <= '0;
        end else if (idle_q[p] != IDLE_W'(IDLE_CYCLES)) begin
          idle_q[p] <= idle_q[p] + 1'b1;
        end
      end
    end
  end

  // Idle flag is simply "counter saturated".
  always_comb begin
    port_idle = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_idle[p] = (idle_q[p] == IDLE_W'(IDLE_CYCLES));
    end
  end

endmodule

// File: tb/tb_maple_port_mux.sv
// Bench for maple_port_mux: random line activity against a history-window model, then directed switching.
// Latency: n/a.
// Backpressure: n/a.
module tb_maple_port_mux;

  localparam int NP = 4;
  localparam int SS = 2;
  localparam int FL = 3;
  localparam int GC = 16;
  localparam int IC = 64;
  localparam int HMAX = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel_valid, out_p1, out_p5, oe;
  logic [1:0] sel_req;
  wire        sel_ready, sel_err, in_p1, in_p5;
  wire  [1:0] active_sel;
  wire  [3:0] port_idle;
  wire  [3:0] pin1, pin5;
  logic [3:0] e1, e5;

  logic       sel_valid3;
  logic [1:0] sel_req3;
  wire        sel_ready3, sel_err3, in3_p1, in3_p5;
  wire  [1:0] active_sel3;
  wire  [2:0] port_idle3;
  wire  [2:0] q1, q5;
  logic       lo0 = 1'b0;
  logic       hi1 = 1'b1;

  // Pull-ups plus external devices that can pull each line low.
  for (genvar g = 0; g < NP; g++) begin : g_ext
    pullup pu1 (pin1[g]);
    pullup pu5 (pin5[g]);
    assign pin1[g] = e1[g] ? 1'b0 : 1'bz;
    assign pin5[g] = e5[g] ? 1'b0 : 1'bz;
  end
  for (genvar g = 0; g < 3; g++) begin : g_ext3
    pullup pq1 (q1[g]);
    pullup pq5 (q5[g]);
  end

  maple_port_mux #(.NUM_PORTS(NP), .SYNC_STAGES(SS), .FILTER_LEN(FL),
                   .GUARD_CYCLES(GC), .IDLE_CYCLES(IC)) u_dut (
    .clk(clk), .rst(rst), .pin1(pin1), .pin5(pin5), .sel_req(sel_req),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_err(sel_err),
    .active_sel(active_sel), .out_p1(out_p1), .out_p5(out_p5), .oe(oe),
    .in_p1(in_p1), .in_p5(in_p5), .port_idle(port_idle)
  );

  maple_port_mux #(.NUM_PORTS(3)) u_dut3 (
    .clk(clk), .rst(rst), .pin1(q1), .pin5(q5), .sel_req(sel_req3),
    .sel_valid(sel_valid3), .sel_ready(sel_ready3), .sel_err(sel_err3),
    .active_sel(active_sel3), .out_p1(hi1), .out_p5(hi1), .oe(lo0),
    .in_p1(in3_p1), .in_p5(in3_p5), .port_idle(port_idle3)
  );

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;
  int ncyc  = 0;
  logic [3:0] h1 [0:HMAX-1];
  logic [3:0] h5 [0:HMAX-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record the line levels the bench is imposing, then settle past the edge.
  task automatic step();
    @(posedge clk);
    ncyc++;
    if (ncyc < HMAX) begin
      h1[ncyc] = ~e1;
      h5[ncyc] = ~e5;
    end
    #1;
  endtask

  // Synchronised level seen by the logic at edge m: the pin as it was SS edges earlier.
  function automatic logic ysync(input int line, input int p, input int m);
    if (m - SS < 1) return 1'b1;
    return (line == 1) ? h1[m-SS][p] : h5[m-SS][p];
  endfunction

  // Filtered output after edge n: takes y(n) if the last FL synced samples all agree.
  function automatic logic filt_next(input int line, input int p, input int n, input logic prev);
    for (int k = 1; k < FL; k++) begin
      if (ysync(line, p, n - k) !== ysync(line, p, n)) return prev;
    end
    return ysync(line, p, n);
  endfunction

  // Idle after edge n: the IC synced samples ending at edge n were all high on both lines.
  function automatic logic [3:0] idle_model(input int n);
    logic [3:0] r;
    r = '0;
    if (n >= IC + SS) begin
      r = 4'hF;
      for (int k = n - IC - SS + 1; k <= n - SS; k++) begin
        r = r & h1[k] & h5[k];
      end
    end
    return r;
  endfunction

  initial begin
    logic       ef1, ef5;
    logic [3:0] exp_pins;
    int         lows, first;

    rst = 1'b1; sel_valid = 1'b0; sel_req = '0; oe = 1'b0; out_p1 = 1'b1; out_p5 = 1'b1;
    e1 = '0; e5 = '0; sel_valid3 = 1'b0; sel_req3 = '0;
    repeat (3) step();
    chk("rst_active_sel", active_sel, 0);
    chk("rst_sel_ready", sel_ready, 1);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_in_p1", in_p1, 1);
    chk("rst_in_p5", in_p5, 1);
    chk("rst_port_idle", port_idle, 0);

    // Floating lines first (idle rise timing), then random pulls; port 0 stays active.
    rst = 1'b0;
    ncyc = 0;
    ef1 = 1'b1; ef5 = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      if (n > 70) begin
        for (int p = 0; p < NP; p++) begin
          if (e1[p]) e1[p] = ($urandom_range(0, 2) != 0);
          else       e1[p] = ($urandom_range(0, (16 << p) - 1) == 0);
          if (e5[p]) e5[p] = ($urandom_range(0, 2) != 0);
          else       e5[p] = ($urandom_range(0, (16 << p) - 1) == 0);
        end
      end
      step();
      ef1 = filt_next(1, 0, n, ef1);
      ef5 = filt_next(5, 0, n, ef5);
      chk("rnd_in_p1", in_p1, ef1);
      chk("rnd_in_p5", in_p5, ef5);
      chk("rnd_port_idle", port_idle, idle_model(n));
    end
    e1 = '0; e5 = '0;
    repeat (70) step();

    // Switch 0 -> 2 with oe low.
    sel_req = 2'd2; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    chk("sw2_drain_ready", sel_ready, 0);
    step();
    repeat (GC - 1) step();
    chk("sw2_guard_ready", sel_ready, 0);
    chk("sw2_guard_sel", active_sel, 0);
    step();
    chk("sw2_ready", sel_ready, 1);
    chk("sw2_sel", active_sel, 2);

    // Drive pin 1 low on port 2: combinational pull, filtered input falls 5 edges later.
    oe = 1'b1; out_p1 = 1'b0;
    #1;
    exp_pins = 4'hF;
    exp_pins[2] = 1'b0;
    chk("drv_pin1", pin1, exp_pins);
    chk("drv_pin5", pin5, 4'hF);
    repeat (4) step();
    chk("drv_in_p1_early", in_p1, 1);
    step();
    chk("drv_in_p1_low", in_p1, 0);
    chk("drv_in_p5", in_p5, 1);

    // Request port 3 while the engine still drives: stay in DRAIN with pins released.
    sel_req = 2'd3; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    chk("drain_pins1", pin1, 4'hF);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("drain_ready", sel_ready, 0);
      chk("drain_pins1_hold", pin1, 4'hF);
    end
    oe = 1'b0; out_p1 = 1'b1;
    step();
    repeat (GC - 1) step();
    chk("sw3_guard_ready", sel_ready, 0);
    chk("sw3_guard_sel", active_sel, 2);
    step();
    chk("sw3_ready", sel_ready, 1);
    chk("sw3_sel", active_sel, 3);
    repeat (10) step();

    // Two-cycle glitch on active port's pin 5 is swallowed.
    e5[3] = 1'b1;
    step(); step();
    e5[3] = 1'b0;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!in_p5) lows++;
    end
    chk("glitch2_lows", lows, 0);

    // Three-cycle pulse passes through, delayed by 5 edges.
    e5[3] = 1'b1;
    lows = 0; first = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) e5[3] = 1'b0;
      if (!in_p5) begin
        lows++;
        if (first < 0) first = k;
      end
    end
    chk("pulse3_lows", lows, 3);
    chk("pulse3_first", first, 5);

    // Request for the already-active port is a no-op.
    sel_req = 2'd3; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    chk("noop_ready", sel_ready, 1);
    chk("noop_sel", active_sel, 3);
    chk("noop_err", sel_err, 0);
    step();
    chk("noop_ready2", sel_ready, 1);

    // Three-port instance: index 3 is rejected, index 0 while on 0 is a no-op.
    sel_req3 = 2'd3; sel_valid3 = 1'b1;
    step();
    sel_valid3 = 1'b0;
    chk("np3_err_pulse", sel_err3, 1);
    chk("np3_sel", active_sel3, 0);
    chk("np3_ready", sel_ready3, 1);
    step();
    chk("np3_err_clear", sel_err3, 0);
    sel_req3 = 2'd0; sel_valid3 = 1'b1;
    step();
    sel_valid3 = 1'b0;
    chk("np3_noop_ready", sel_ready3, 1);
    chk("np3_noop_sel", active_sel3, 0);
    chk("np3_noop_err", sel_err3, 0);

    // Reset in the middle of the guard interval aborts the switch.
    sel_req = 2'd1; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    step();
    repeat (3) step();
    chk("abort_pre_ready", sel_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_sel", active_sel, 0);
    chk("abort_ready", sel_ready, 1);
    chk("abort_err", sel_err, 0);
    chk("abort_idle", port_idle, 0);
    chk("abort_in_p1", in_p1, 1);
    repeat (20) step();
    chk("abort_sel_hold", active_sel, 0);
    chk("abort_ready_hold", sel_ready, 1);
    chk("abort_idle_hold", port_idle, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
